// File: rtl/demux_4x_nbit_reg_if.sv
// Bus bundle for demux_4x_nbit_reg: one valid/ready input stream with a 2-bit
// select, and four valid/ready output channels a..d plus busy.
interface demux_4x_nbit_reg_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] a, b, c, d;
    logic                 a_valid, b_valid, c_valid, d_valid;
    logic                 a_ready, b_ready, c_ready, d_ready;
    logic                 busy;

    // Producer and consumers together form the master side.
    modport master (
        output in_data, in_sel, in_valid,
        output a_ready, b_ready, c_ready, d_ready,
        input  in_ready, a, b, c, d,
        input  a_valid, b_valid, c_valid, d_valid, busy
    );

    modport slave (
        input  in_data, in_sel, in_valid,
        input  a_ready, b_ready, c_ready, d_ready,
        output in_ready, a, b, c, d,
        output a_valid, b_valid, c_valid, d_valid, busy
    );
endinterface

// File: rtl/demux_4x_nbit_reg.sv
// Registered 1-to-4 demux: one-entry register per output channel, each with an
// independent handshake. Optional per-channel transfer counters: DEMUX_4X_NBIT_CNT_EN.
module demux_4x_nbit_reg_ch #(
    parameter int BUS_WIDTH = 8
`ifdef DEMUX_4X_NBIT_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] load_data,
    input  logic                 rdy,
    output logic [BUS_WIDTH-1:0] q,
    output logic                 vld,
    output logic                 free
`ifdef DEMUX_4X_NBIT_CNT_EN
    , output logic [CNT_WIDTH-1:0] cnt
`endif
);
    // A draining channel is free, so load and drain can share an edge.
    assign free = !vld | rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (load) begin
            q   <= load_data;
            vld <= 1'b1;
        end else if (vld && rdy) begin
            vld <= 1'b0;
        end
    end

`ifdef DEMUX_4X_NBIT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (vld && rdy)
            cnt <= cnt + 1'b1;
    end
`endif
endmodule

module demux_4x_nbit_reg #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    demux_4x_nbit_reg_if.slave   bus
`ifdef DEMUX_4X_NBIT_CNT_EN
    , output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0]   cnt_b,
    output logic [CNT_WIDTH-1:0]   cnt_c,
    output logic [CNT_WIDTH-1:0]   cnt_d
`endif
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]                ld, rdy, vld, free;
    logic [NUM_LANES-1:0][BUS_WIDTH-1:0] q;
`ifdef DEMUX_4X_NBIT_CNT_EN
    logic [NUM_LANES-1:0][CNT_WIDTH-1:0] cnt;
`endif

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    assign rdy          = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    assign bus.in_ready = free[bus.in_sel];

    always_comb begin
        ld              = '0;
        ld[bus.in_sel]  = bus.in_valid & bus.in_ready;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
        demux_4x_nbit_reg_ch #(
            .BUS_WIDTH(BUS_WIDTH)
`ifdef DEMUX_4X_NBIT_CNT_EN
            , .CNT_WIDTH(CNT_WIDTH)
`endif
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (ld[i]),
            .load_data (bus.in_data),
            .rdy       (rdy[i]),
            .q         (q[i]),
            .vld       (vld[i]),
            .free      (free[i])
`ifdef DEMUX_4X_NBIT_CNT_EN
            , .cnt     (cnt[i])
`endif
        );
    end

    assign bus.a       = q[0];
    assign bus.b       = q[1];
    assign bus.c       = q[2];
    assign bus.d       = q[3];
    assign bus.a_valid = vld[0];
    assign bus.b_valid = vld[1];
    assign bus.c_valid = vld[2];
    assign bus.d_valid = vld[3];
    assign bus.busy    = |vld;

`ifdef DEMUX_4X_NBIT_CNT_EN
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
    assign cnt_c = cnt[2];
    assign cnt_d = cnt[3];
`endif
endmodule

// File: tb/tb_demux_4x_nbit_reg.sv
// Directed vector table plus hand sequences and a random scoreboard run for
// demux_4x_nbit_reg.
module tb_demux_4x_nbit_reg;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    demux_4x_nbit_reg_if #(.BUS_WIDTH(W)) bus ();
`ifdef DEMUX_4X_NBIT_CNT_EN
    logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    demux_4x_nbit_reg #(.BUS_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DEMUX_4X_NBIT_CNT_EN
        , .cnt_a (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_c   (cnt_c),
        .cnt_d   (cnt_d)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vlds();
        return {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
    endfunction

    function automatic logic [W-1:0] chq(input int k);
        case (k)
            0:       return bus.a;
            1:       return bus.b;
            2:       return bus.c;
            default: return bus.d;
        endcase
    endfunction

    task automatic drive(input logic [1:0] sel, input logic [W-1:0] data,
                         input logic v, input logic [3:0] rdy);
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.in_valid = v;
        {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(2'd0, '0, 1'b0, 4'hF);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
        logic         v;
        logic [3:0]   rdy;
        logic         ir;   // in_ready before the edge
        logic [3:0]   vld;  // {d,c,b,a}_valid after the edge
        int           ch;   // channel whose data is checked after the edge
        logic [W-1:0] q;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] sel, input logic [W-1:0] data, input logic v,
                                input logic [3:0] rdy, input logic ir, input logic [3:0] vld,
                                input int ch, input logic [W-1:0] q);
        vec_t t;
        t.sel = sel; t.data = data; t.v = v; t.rdy = rdy;
        t.ir = ir; t.vld = vld; t.ch = ch; t.q = q;
        return t;
    endfunction

    vec_t tbl[14];

    // Reference state for the random run: modelled valids and per-channel queues.
    logic [3:0]   mv;
    logic [W-1:0] sbq[4][$];

    task automatic rnd_step(input logic [1:0] sel, input logic [W-1:0] data,
                            input logic v, input logic [3:0] rdy);
        logic         eir;
        logic [3:0]   dv;
        logic [W-1:0] e;
        drive(sel, data, v, rdy);
        #1;
        eir = !mv[sel] | rdy[sel];
        chk("rnd_in_ready", bus.in_ready, eir);
        dv = vlds();
        for (int k = 0; k < 4; k++) begin
            if (dv[k] && rdy[k]) begin
                if (sbq[k].size() == 0) begin
                    chk("rnd_extra_word", 1, 0);
                end else begin
                    e = sbq[k].pop_front();
                    chk("rnd_data", chq(k), e);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (v && eir && sel == k) mv[k] = 1'b1;
            else if (mv[k] && rdy[k]) mv[k] = 1'b0;
        end
        if (v && eir) sbq[sel].push_back(data);
        @(negedge clk);
        chk("rnd_valids", vlds(), mv);
    endtask

    initial begin
        // Routing, all channels ready
        tbl[0]  = mk(2'd0, 8'h11, 1, 4'hF, 1, 4'b0001, 0, 8'h11);
        tbl[1]  = mk(2'd1, 8'h22, 1, 4'hF, 1, 4'b0010, 1, 8'h22);
        tbl[2]  = mk(2'd2, 8'h33, 1, 4'hF, 1, 4'b0100, 2, 8'h33);
        tbl[3]  = mk(2'd3, 8'h44, 1, 4'hF, 1, 4'b1000, 3, 8'h44);
        tbl[4]  = mk(2'd0, 8'h00, 0, 4'hF, 1, 4'b0000, 3, 8'h44);
        // Stall on c, then drain+load on the same edge
        tbl[5]  = mk(2'd2, 8'h5A, 1, 4'b1011, 1, 4'b0100, 2, 8'h5A);
        tbl[6]  = mk(2'd2, 8'hA5, 1, 4'b1011, 0, 4'b0100, 2, 8'h5A);
        tbl[7]  = mk(2'd2, 8'hA5, 1, 4'hF,    1, 4'b0100, 2, 8'hA5);
        tbl[8]  = mk(2'd2, 8'h00, 0, 4'hF,    1, 4'b0000, 2, 8'hA5);
        // d stalled, a still accepted
        tbl[9]  = mk(2'd3, 8'h77, 1, 4'b0111, 1, 4'b1000, 3, 8'h77);
        tbl[10] = mk(2'd3, 8'h99, 1, 4'b0111, 0, 4'b1000, 3, 8'h77);
        tbl[11] = mk(2'd0, 8'h01, 1, 4'b0111, 1, 4'b1001, 0, 8'h01);
        tbl[12] = mk(2'd3, 8'h00, 0, 4'b0111, 0, 4'b1000, 3, 8'h77);
        tbl[13] = mk(2'd3, 8'h00, 0, 4'hF,    1, 4'b0000, 3, 8'h77);

        // Reset state
        reset_n = 1'b0;
        drive(2'd0, '0, 1'b0, 4'hF);
        #1;
        chk("rst_valids", vlds(), 4'b0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_data", {bus.d, bus.c, bus.b, bus.a}, 32'h0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].sel, tbl[i].data, tbl[i].v, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d_in_ready", i), bus.in_ready, tbl[i].ir);
            @(negedge clk);
            chk($sformatf("v%0d_valids", i), vlds(), tbl[i].vld);
            chk($sformatf("v%0d_busy", i), bus.busy, |tbl[i].vld);
            chk($sformatf("v%0d_data", i), chq(tbl[i].ch), tbl[i].q);
        end

        // Asynchronous reset while b is stalled holding a word
        drive(2'd1, 8'h3C, 1'b1, 4'b1101);
        @(negedge clk);
        chk("stall_b_valid", bus.b_valid, 1'b1);
        chk("stall_b_data", bus.b, 8'h3C);
        drive(2'd1, 8'h00, 1'b0, 4'b1101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_b_valid", bus.b_valid, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_b_data", bus.b, 8'h00);
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = s[1:0];
            #1;
            chk($sformatf("arst_in_ready_sel%0d", s), bus.in_ready, 1'b1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valids", vlds(), 4'b0000);

        // Back-to-back throughput on channel a
        begin
`ifdef DEMUX_4X_NBIT_CNT_EN
            logic [CW-1:0] c0;
            c0 = cnt_a;
`endif
            for (int i = 0; i < 16; i++) begin
                drive(2'd0, W'(i), 1'b1, 4'hF);
                #1;
                chk($sformatf("tput%0d_in_ready", i), bus.in_ready, 1'b1);
                @(negedge clk);
                chk($sformatf("tput%0d_a", i), bus.a, W'(i));
                chk($sformatf("tput%0d_a_valid", i), bus.a_valid, 1'b1);
            end
            drive(2'd0, '0, 1'b0, 4'hF);
            @(negedge clk);
            chk("tput_drained", bus.a_valid, 1'b0);
`ifdef DEMUX_4X_NBIT_CNT_EN
            chk("tput_cnt_a", cnt_a, CW'(c0 + 16));
`endif
        end

`ifdef DEMUX_4X_NBIT_CNT_EN
        // 17 transfers on b wrap a 4-bit counter to 1
        do_reset();
        chk("cnt_rst", {cnt_d, cnt_c, cnt_b, cnt_a}, 32'h0);
        for (int i = 0; i < 17; i++) begin
            drive(2'd1, W'(i + 1), 1'b1, 4'hF);
            @(negedge clk);
        end
        drive(2'd1, '0, 1'b0, 4'hF);
        @(negedge clk);
        chk("cnt_b_wrap", cnt_b, 4'd1);
        chk("cnt_a_idle", cnt_a, 4'd0);
`endif

        // Random traffic against the reference model and scoreboard
        do_reset();
        mv = 4'b0000;
        for (int i = 0; i < 200; i++)
            rnd_step(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)),
                     4'($urandom));
        rnd_step(2'd0, '0, 1'b0, 4'hF);
        chk("rnd_leftover", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
